// File: rtl/apb_slave_array.sv
// APB slave responder bank: NUM_SLAVES select lines, each backed by a DEPTH-word
// register file, with programmable wait states, byte strobes, pslverr and a sticky protocol flag.
module apb_slave_array #(
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_SLAVES-1:0]   pselx,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_W-1:0]       paddr,
  input  logic [DATA_W-1:0]       pwdata,
  input  logic [DATA_W/8-1:0]     pstrb,
  output logic [DATA_W-1:0]       prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic                    proto_err
);

  localparam int NB = DATA_W / 8;
  localparam int BL = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(DEPTH * NB);
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(NB - 1);

  // Handshake: a transfer is set up on an edge with |pselx & !penable and
  // completes on the edge where penable & pready are both high.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t                state, state_n;
  logic [DATA_W-1:0]     mem [NUM_SLAVES][DEPTH];

  logic [SW-1:0]         cur_slave, cur_slave_n;
  logic                  cur_err, cur_err_n;
  logic [NUM_SLAVES-1:0] lat_psel, lat_psel_n;
  logic [ADDR_W-1:0]     lat_addr, lat_addr_n;
  logic                  lat_write, lat_write_n;
  logic [3:0]            cnt, cnt_n;
  logic [DATA_W-1:0]     prdata_n;
  logic                  pready_n, pslverr_n, proto_n;
  logic                  mem_we;

  logic [SW-1:0]         dec_slave;
  logic [IW-1:0]         dec_idx, cur_idx;
  logic                  dec_err, multi, changed;

  assign cur_idx = lat_addr[BL +: IW];

  always_comb begin
    dec_slave = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (pselx[i]) dec_slave = SW'(i);
    multi   = (pselx & (pselx - 1'b1)) != '0;
    dec_idx = paddr[BL +: IW];
    dec_err = multi || ((paddr & LANE_MASK) != '0) || (paddr >= SPAN);
  end

  always_comb begin
    state_n     = state;
    cur_slave_n = cur_slave;
    cur_err_n   = cur_err;
    lat_psel_n  = lat_psel;
    lat_addr_n  = lat_addr;
    lat_write_n = lat_write;
    cnt_n       = cnt;
    prdata_n    = prdata;
    pready_n    = pready;
    pslverr_n   = pslverr;
    proto_n     = proto_err;
    mem_we      = 1'b0;
    // A dropped select also shows up as a change against the latched select.
    changed = (pselx != lat_psel) || (paddr != lat_addr) || (pwrite != lat_write);

    case (state)
      S_IDLE: begin
        if (penable) begin
          proto_n = 1'b1;
        end else if (|pselx) begin
          cur_slave_n = dec_slave;
          cur_err_n   = dec_err;
          lat_psel_n  = pselx;
          lat_addr_n  = paddr;
          lat_write_n = pwrite;
          cnt_n       = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_n   = S_READY;
            pready_n  = 1'b1;
            pslverr_n = dec_err;
            prdata_n  = (!dec_err && !pwrite) ? mem[dec_slave][dec_idx] : '0;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (changed) begin
          state_n = S_IDLE;
          proto_n = 1'b1;
        end else if (penable) begin
          cnt_n = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_n   = S_READY;
            pready_n  = 1'b1;
            pslverr_n = cur_err;
            prdata_n  = (!cur_err && !lat_write) ? mem[cur_slave][cur_idx] : '0;
          end
        end
      end
      S_READY: begin
        if (changed) begin
          state_n   = S_IDLE;
          pready_n  = 1'b0;
          pslverr_n = 1'b0;
          prdata_n  = '0;
          proto_n   = 1'b1;
        end else if (penable) begin
          state_n   = S_IDLE;
          pready_n  = 1'b0;
          pslverr_n = 1'b0;
          prdata_n  = '0;
          mem_we    = lat_write && !cur_err;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_slave <= '0;
      cur_err   <= 1'b0;
      lat_psel  <= '0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      cnt       <= '0;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_n;
      cur_slave <= cur_slave_n;
      cur_err   <= cur_err_n;
      lat_psel  <= lat_psel_n;
      lat_addr  <= lat_addr_n;
      lat_write <= lat_write_n;
      cnt       <= cnt_n;
      prdata    <= prdata_n;
      pready    <= pready_n;
      pslverr   <= pslverr_n;
      proto_err <= proto_n;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SLAVES; s++)
        for (int d = 0; d < DEPTH; d++)
          mem[s][d] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < NB; b++)
        if (pstrb[b]) mem[cur_slave][cur_idx][8*b +: 8] <= pwdata[8*b +: 8];
    end
  end

endmodule

// File: doc/apb_slave_array.md
Name: apb_slave_array

Overview:
- Synthesizable, parametrised APB slave responder bank that sits on the bridge's APB side in place of the bench-only responder.
- Serves NUM_SLAVES independent select lines, each backed by a DEPTH-word register file.
- Supports programmable wait states (pready), byte strobes, and pslverr on decode and protocol faults.
- Gives the AHB-APB bridge a real target for multi-slave, wait-state and error-path testing.

Parameters:
- NUM_SLAVES, 4, number of pselx lines and independent register files
- ADDR_W, 32, paddr width
- DATA_W, 32, pwdata/prdata width (multiple of 8)
- DEPTH, 16, words per slave (power of 2)
- WAIT_CYCLES, 0, access-phase cycles with pready low before pready rises (0..15)

Ports:
- clock  input  1  sole clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- pselx  input  NUM_SLAVES  one-hot slave select
- penable  input  1  APB access phase
- pwrite  input  1  1 = write, 0 = read
- paddr  input  ADDR_W  byte address
- pwdata  input  DATA_W  write data
- pstrb  input  DATA_W/8  write byte strobes
- prdata  output  DATA_W  read data, valid while pready=1
- pready  output  1  transfer completes on edge with penable&pready
- pslverr  output  1  error flag, valid while pready=1
- proto_err  output  1  sticky: protocol violation seen since reset

Behaviour:
- Reset (async, active-high): prdata=0, pready=0, pslverr=0, proto_err=0, state=IDLE, all register-file words=0.
- Decode:
  - BL = log2(DATA_W/8); word index = paddr[BL +: log2(DEPTH)]; slave = index of the set pselx bit.
  - Error (err=1) when more than one pselx bit is set, paddr[BL-1:0] != 0, or paddr >= DEPTH*(DATA_W/8).
- States: IDLE, WAIT, READY.
- IDLE:
  - On edge with |pselx & !penable (setup phase), latch slave, index, pwrite, err, and counter=WAIT_CYCLES.
  - If WAIT_CYCLES==0, go to READY and set pready=1. Otherwise go to WAIT.
  - Read with !err: prdata loaded from the word at the edge entering READY. Err or write: prdata=0.
  - pslverr=err, registered at the same edge pready rises.
- WAIT:
  - Each edge with penable=1 decrements counter.
  - When counter reaches 1→0, go to READY with pready=1.
- READY:
  - At the edge with penable=1, the transfer completes. For a write with !err, each byte lane with pstrb[i]=1 is written.
  - Same edge: pready=0, pslverr=0, prdata=0, go to IDLE.
- Latency: pready is high in access cycle WAIT_CYCLES+1. A zero-wait transfer takes 2 cycles (setup + access).
- Back-to-back: a new setup in the cycle after completion is accepted from IDLE with no bubble.
- Errored transfers never modify memory but still complete with normal wait timing.
- Abort: if pselx drops to 0 in WAIT or READY, go to IDLE, no write, outputs cleared, proto_err=1.
- Protocol violations set proto_err=1 (cleared only by reset); the block stays in or returns to IDLE:
  - penable=1 in IDLE.
  - pselx, paddr or pwrite changing between setup and completion.
- Reset asserted mid-transfer: immediate return to reset values; no partial write.

Test Plan:
- Zero-wait write then read:
  - Write slave 0, paddr=0x8, pwdata=0xDEADBEEF, pstrb=0xF → pready high in cycle 2, pslverr=0.
  - Read same address → prdata=0xDEADBEEF in the access cycle.
- WAIT_CYCLES=3, read slave 2, paddr=0x0 after reset → pready low for 3 access cycles, high in the 4th, prdata=0x00000000.
- Partial strobe:
  - Word 0x11223344, write pwdata=0xAABBCCDD with pstrb=0b0101 → readback 0x11BB33DD.
  - Same address on slave 1 still reads 0.
- Error paths, each → pslverr=1, prdata=0, memory unchanged:
  - paddr=0x40 (DEPTH 16) → out of range.
  - paddr=0x2 → misaligned.
  - pselx=4'b0011 → multiple selects.
- Abort and violation:
  - pselx dropped during WAIT → no write, proto_err=1.
  - penable=1 with no prior setup → proto_err=1, pready stays 0.
- Reset mid-WAIT of a write → all outputs 0, target word still 0, next transfer completes normally.
